// File: rtl/uart_rx_fsm.sv
// UART receive sequencer: walks start/data/parity/stop bits on an oversampled
// edge counter and strobes the sampler, deserializer and frame checkers.
module uart_rx_fsm #(
    parameter int DATA_WIDTH = 8,
    parameter int PRESC_W    = 6,
    parameter int BITC_W     = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               RX_IN,
    input  logic               PAR_EN,
    input  logic [PRESC_W-1:0] prescale,
    input  logic               strt_glitch,
    input  logic               par_err,
    input  logic               stp_err,
    output logic [PRESC_W-1:0] edge_cnt,
    output logic [BITC_W-1:0]  bit_cnt,
    output logic               dat_samp_en,
    output logic               deser_en,
    output logic               strt_chk_en,
    output logic               par_chk_en,
    output logic               stp_chk_en,
    output logic               finish_s,
    output logic               disable_err,
    output logic               data_valid
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_DONE   = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [PRESC_W-1:0] edge_q, edge_d;
    logic [PRESC_W-1:0] p_q, p_d;
    logic [BITC_W-1:0]  bit_q, bit_d;
    logic [PRESC_W-1:0] presc_even_s;
    logic [PRESC_W-1:0] presc_norm_s;
    logic [PRESC_W-1:0] half_s;
    logic               last_edge_s;
    logic               fin_hit_s;
    logic               enter_start_s;

    assign presc_even_s = {prescale[PRESC_W-1:1], 1'b0};
    assign half_s       = p_q >> 1;
    assign last_edge_s  = (edge_q == (p_q - PRESC_W'(1)));
    assign fin_hit_s    = (edge_q == (half_s + PRESC_W'(2)));

    // Clamp the oversampling ratio so the checker flags always settle before they are read
    always_comb begin
        if (presc_even_s < PRESC_W'(8)) begin
            presc_norm_s = PRESC_W'(8);
        end else begin
            presc_norm_s = presc_even_s;
        end
    end

    // Next-state decision for the frame walk
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (!RX_IN) state_d = S_START;
                else        state_d = S_IDLE;
            end
            S_START: begin
                if (last_edge_s) state_d = strt_glitch ? S_IDLE : S_DATA;
                else             state_d = S_START;
            end
            S_DATA: begin
                if (last_edge_s && (bit_q == BITC_W'(DATA_WIDTH))) state_d = PAR_EN ? S_PARITY : S_STOP;
                else                                               state_d = S_DATA;
            end
            S_PARITY: begin
                if (last_edge_s) state_d = S_STOP;
                else             state_d = S_PARITY;
            end
            S_STOP: begin
                if (last_edge_s) state_d = S_DONE;
                else             state_d = S_STOP;
            end
            S_DONE: begin
                if (!RX_IN) state_d = S_START;
                else        state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Edge/bit counters and the prescale latch; P is only taken when a frame starts from idle
    always_comb begin
        enter_start_s = (state_d == S_START) && (state_q != S_START);
        if (enter_start_s || (state_d == S_IDLE)) begin
            edge_d = '0;
            bit_d  = '0;
        end else if (last_edge_s) begin
            edge_d = '0;
            bit_d  = bit_q + BITC_W'(1);
        end else begin
            edge_d = edge_q + PRESC_W'(1);
            bit_d  = bit_q;
        end
        if ((state_q == S_IDLE) && enter_start_s) begin
            p_d = presc_norm_s;
        end else begin
            p_d = p_q;
        end
    end

    // State and counter registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            edge_q  <= '0;
            bit_q   <= '0;
            p_q     <= PRESC_W'(8);
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            p_q     <= p_d;
        end
    end

    // Strobe decode from registered state and counters only
    always_comb begin
        dat_samp_en = 1'b0;
        deser_en    = 1'b0;
        strt_chk_en = 1'b0;
        par_chk_en  = 1'b0;
        stp_chk_en  = 1'b0;
        finish_s    = 1'b0;
        disable_err = 1'b0;
        data_valid  = 1'b0;
        case (state_q)
            S_START: begin
                dat_samp_en = 1'b1;
                strt_chk_en = 1'b1;
                finish_s    = fin_hit_s;
                disable_err = last_edge_s & strt_glitch;
            end
            S_DATA: begin
                dat_samp_en = 1'b1;
                deser_en    = 1'b1;
                finish_s    = fin_hit_s;
            end
            S_PARITY: begin
                dat_samp_en = 1'b1;
                par_chk_en  = 1'b1;
                finish_s    = fin_hit_s;
            end
            S_STOP: begin
                dat_samp_en = 1'b1;
                stp_chk_en  = 1'b1;
                finish_s    = fin_hit_s;
            end
            S_DONE: begin
                disable_err = 1'b1;
                data_valid  = ~par_err & ~stp_err;
            end
            default: begin
                dat_samp_en = 1'b0;
            end
        endcase
    end

    assign edge_cnt = edge_q;
    assign bit_cnt  = bit_q;

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Scoreboard bench for uart_rx_fsm: frames are driven on RX_IN with a small
// behavioural sampler/checker stub; per-frame expectations are queued and popped at frame end.
module tb_uart_rx_fsm;

    localparam int PW = 6;
    localparam int BW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b0;
    logic          RX_IN = 1'b1;
    logic          PAR_EN = 1'b0;
    logic [PW-1:0] prescale = 6'd8;
    logic          strt_glitch = 1'b0;
    logic          par_err = 1'b0;
    logic          stp_err = 1'b0;
    logic [PW-1:0] edge_cnt;
    logic [BW-1:0] bit_cnt;
    logic          dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic          finish_s, disable_err, data_valid;

    uart_rx_fsm #(.DATA_WIDTH(8), .PRESC_W(PW), .BITC_W(BW)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .prescale(prescale),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .finish_s(finish_s), .disable_err(disable_err),
        .data_valid(data_valid)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int dv; int len; int nfin; int ndeser; int npar; int nstp; int nsamp;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   drv_p    = 8;
    logic par_exp  = 1'b0;
    logic samp_r   = 1'b1;

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // Stub of the sampler and the three checkers: mid-bit sample, flags latch on finish_s
    always @(posedge CLK or posedge RST) begin
        if (RST) begin
            samp_r      <= 1'b1;
            strt_glitch <= 1'b0;
            par_err     <= 1'b0;
            stp_err     <= 1'b0;
        end else begin
            if (dat_samp_en && (int'(edge_cnt) == drv_p / 2)) samp_r <= RX_IN;
            if (disable_err) begin
                strt_glitch <= 1'b0;
                par_err     <= 1'b0;
                stp_err     <= 1'b0;
            end else if (finish_s) begin
                if (strt_chk_en) strt_glitch <= samp_r;
                if (par_chk_en)  par_err     <= samp_r ^ par_exp;
                if (stp_chk_en)  stp_err     <= ~samp_r;
            end
        end
    end

    // Frame monitor: accumulates strobe counts and pops the scoreboard on each disable_err
    initial begin
        bit   in_frame = 1'b0;
        bit   prev_strt = 1'b0;
        int   cyc = 0, m_fin = 0, m_deser = 0, m_par = 0, m_stp = 0, m_samp = 0;
        exp_t e;
        forever begin
            @(negedge CLK);
            if (RST) begin
                in_frame  = 1'b0;
                prev_strt = 1'b0;
            end else begin
                if (strt_chk_en && !prev_strt) begin
                    in_frame = 1'b1;
                    cyc = 0; m_fin = 0; m_deser = 0; m_par = 0; m_stp = 0; m_samp = 0;
                end else if (in_frame) begin
                    cyc++;
                end
                if (in_frame) begin
                    m_fin   += int'(finish_s);
                    m_deser += int'(deser_en);
                    m_par   += int'(par_chk_en);
                    m_stp   += int'(stp_chk_en);
                    m_samp  += int'(dat_samp_en);
                    if (finish_s) check_eq("fin_edge", int'(edge_cnt), drv_p / 2 + 2);
                end
                if (disable_err) begin
                    check_eq("end_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check_eq("data_valid", int'(data_valid), e.dv);
                        check_eq("frame_len", cyc, e.len);
                        check_eq("n_finish", m_fin, e.nfin);
                        check_eq("n_deser", m_deser, e.ndeser);
                        check_eq("n_par_chk", m_par, e.npar);
                        check_eq("n_stp_chk", m_stp, e.nstp);
                        check_eq("n_samp", m_samp, e.nsamp);
                    end
                    in_frame = 1'b0;
                end
                if (data_valid) check_eq("dv_in_done", int'(disable_err), 1);
                prev_strt = strt_chk_en;
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic drive_frame(input logic [7:0] data, input logic pen, input logic pbad,
                               input logic stopb, input logic [PW-1:0] presc, input int pe,
                               input int chg_bit, input logic [PW-1:0] chg_val);
        exp_t e;
        int   nb;
        logic b;
        nb = pen ? 11 : 10;
        e.dv = (!(pen && pbad) && stopb) ? 1 : 0;
        e.len = nb * pe;  e.nfin = nb;  e.ndeser = 8 * pe;
        e.npar = pen ? pe : 0;  e.nstp = pe;  e.nsamp = nb * pe;
        exp_q.push_back(e);
        prescale = presc;
        PAR_EN   = pen;
        par_exp  = ^data;
        drv_p    = pe;
        for (int i = 0; i < nb; i++) begin
            if (i == chg_bit) prescale = chg_val;
            if (i == 0)                      b = 1'b0;
            else if (i <= 8)                 b = data[i-1];
            else if (pen && (i == 9))        b = pbad ? ~(^data) : (^data);
            else                             b = stopb;
            RX_IN = b;
            repeat (pe) @(posedge CLK);
            #1;
        end
        RX_IN = 1'b1;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while ((exp_q.size() != 0) && (n < budget)) begin
            @(posedge CLK);
            n++;
        end
        check_eq("drain", exp_q.size(), 0);
        #1;
    endtask

    initial begin
        exp_t g;
        #2 RST = 1'b1;
        #2;
        check_eq("rst_edge_cnt", int'(edge_cnt), 0);
        check_eq("rst_bit_cnt", int'(bit_cnt), 0);
        check_eq("rst_strobes", int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                                      stp_chk_en, finish_s, disable_err, data_valid}), 0);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        idle(3);

        // basic frame, then a start glitch
        drive_frame(8'hA5, 1'b0, 1'b0, 1'b1, 6'd8, 8, -1, 6'd0);
        wait_drain(200);  idle(4);
        g.dv = 0; g.len = 7; g.nfin = 1; g.ndeser = 0; g.npar = 0; g.nstp = 0; g.nsamp = 8;
        exp_q.push_back(g);
        drv_p = 8; prescale = 6'd8;
        RX_IN = 1'b0;
        idle(2);
        RX_IN = 1'b1;
        wait_drain(100);  idle(4);

        // parity error at P=16, then stop error followed by a clean frame
        drive_frame(8'h3C, 1'b1, 1'b1, 1'b1, 6'd16, 16, -1, 6'd0);
        wait_drain(300);  idle(4);
        drive_frame(8'h0F, 1'b0, 1'b0, 1'b0, 6'd8, 8, -1, 6'd0);
        wait_drain(200);  idle(4);
        drive_frame(8'h5A, 1'b0, 1'b0, 1'b1, 6'd8, 8, -1, 6'd0);
        wait_drain(200);  idle(4);

        // back-to-back frames with DONE seeing the next start bit
        drive_frame(8'hC3, 1'b1, 1'b0, 1'b1, 6'd8, 8, -1, 6'd0);
        drive_frame(8'h81, 1'b0, 1'b0, 1'b1, 6'd8, 8, -1, 6'd0);
        wait_drain(300);  idle(4);

        // mid-frame prescale change ignored; clamp and LSB masking of prescale
        drive_frame(8'h96, 1'b0, 1'b0, 1'b1, 6'd8, 8, 4, 6'd16);
        wait_drain(200);  idle(4);
        drive_frame(8'h11, 1'b0, 1'b0, 1'b1, 6'd3, 8, -1, 6'd0);
        wait_drain(200);  idle(4);
        drive_frame(8'hEE, 1'b1, 1'b0, 1'b1, 6'd17, 16, -1, 6'd0);
        wait_drain(300);  idle(4);

        // reset during data bit 4
        prescale = 6'd8; drv_p = 8; PAR_EN = 1'b0;
        RX_IN = 1'b0;
        idle(36);
        check_eq("pre_rst_bit_cnt", int'(bit_cnt), 4);
        check_eq("pre_rst_deser", int'(deser_en), 1);
        RST = 1'b1;
        #1;
        check_eq("midrst_edge_cnt", int'(edge_cnt), 0);
        check_eq("midrst_bit_cnt", int'(bit_cnt), 0);
        check_eq("midrst_strobes", int'({dat_samp_en, deser_en, strt_chk_en, par_chk_en,
                                         stp_chk_en, finish_s, disable_err, data_valid}), 0);
        RX_IN = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        idle(3);
        drive_frame(8'h42, 1'b0, 1'b0, 1'b1, 6'd8, 8, -1, 6'd0);
        wait_drain(200);  idle(4);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
